// File: rtl/instr_loader_mem.sv
// Program loader and instruction store for the BRISC core: a length byte, then
// N instructions sent MSB byte first, then fetches served by the PC stage.
module instr_loader_mem #(
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 32,
  parameter int PC_WIDTH    = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic [PC_WIDTH-1:0]    program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   load_done,
  output logic                   load_error,
  output logic [PC_WIDTH-1:0]    instr_count
);

  localparam int BPI = INSTR_WIDTH / 8;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW  = (BPI > 1) ? $clog2(BPI) : 1;

  typedef enum logic [1:0] {WAIT_LEN, LOAD, DONE, ERROR} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [AW-1:0]          r_wrAddr;
  logic [AW-1:0]          r_lastAddr;
  logic [BW-1:0]          r_byteIdx;
  logic [PC_WIDTH-1:0]    r_instrCount;
  logic [INSTR_WIDTH-1:0] r_instruction;
  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

  logic                   w_lenOk;
  logic                   w_lastByte;
  logic                   w_lastWord;
  logic                   w_latchLen;
  logic                   w_take;
  logic                   w_write;
  logic                   w_fetchOk;
  logic [AW-1:0]          w_rdAddr;
  logic [INSTR_WIDTH-1:0] w_asmNext;

  assign w_lenOk    = (rx_data != 8'd0) && (32'(rx_data) <= 32'(DEPTH));
  assign w_lastByte = (r_byteIdx == BW'(BPI - 1));
  assign w_lastWord = (r_wrAddr == r_lastAddr);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= WAIT_LEN;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_latchLen  = 1'b0;
    w_take      = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      WAIT_LEN: begin
        if (rx_valid) begin
          if (w_lenOk) begin
            w_latchLen  = 1'b1;
            w_nextState = LOAD;
          end else begin
            w_nextState = ERROR;
          end
        end
      end
      LOAD: begin
        if (rx_valid) begin
          w_take = 1'b1;
          if (w_lastByte) begin
            w_write = 1'b1;
            if (w_lastWord) w_nextState = DONE;
          end
        end
      end
      default: w_nextState = r_state;
    endcase
  end

  // Earlier bytes of the word wait here; the incoming byte completes the low end.
  if (BPI > 1) begin : g_asm
    logic [INSTR_WIDTH-9:0] r_asm;
    always_ff @(posedge CLK) begin
      if (RST)         r_asm <= '0;
      else if (w_take) r_asm <= w_asmNext[INSTR_WIDTH-9:0];
    end
    assign w_asmNext = {r_asm, rx_data};
  end else begin : g_noAsm
    assign w_asmNext = rx_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wrAddr     <= '0;
      r_lastAddr   <= '0;
      r_byteIdx    <= '0;
      r_instrCount <= '0;
    end else if (w_latchLen) begin
      r_wrAddr     <= '0;
      r_lastAddr   <= AW'(rx_data - 8'd1);
      r_byteIdx    <= '0;
      r_instrCount <= PC_WIDTH'(rx_data);
    end else if (w_take) begin
      if (w_lastByte) begin
        r_byteIdx <= '0;
        r_wrAddr  <= r_wrAddr + AW'(1);
      end else begin
        r_byteIdx <= r_byteIdx + BW'(1);
      end
    end
  end

  // Contents survive reset on purpose; fetches stay gated until a new load completes.
  always_ff @(posedge CLK) begin
    if (!RST && w_write) r_mem[r_wrAddr] <= w_asmNext;
  end

  assign w_rdAddr  = AW'(program_counter);
  assign w_fetchOk = load_done && (program_counter < r_instrCount);

  always_ff @(posedge CLK) begin
    if (RST)            r_instruction <= '0;
    else if (w_fetchOk) r_instruction <= r_mem[w_rdAddr];
    else                r_instruction <= '0;
  end

  assign load_done   = (r_state == DONE);
  assign load_error  = (r_state == ERROR);
  assign instr_count = r_instrCount;
  assign instruction = r_instruction;

endmodule

// File: tb/tb_instr_loader_mem.sv
// Directed bench for instr_loader_mem: loads, fetch gating, bad lengths,
// a full-depth program, reset during a load and post-load immunity.
module tb_instr_loader_mem;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  program_counter;
  logic [15:0] instruction;
  logic        load_done;
  logic        load_error;
  logic [7:0]  instr_count;

  int checks   = 0;
  int failures = 0;

  instr_loader_mem #(.INSTR_WIDTH(16), .DEPTH(32), .PC_WIDTH(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_counter(program_counter),
    .instruction    (instruction),
    .load_done      (load_done),
    .load_error     (load_error),
    .instr_count    (instr_count)
  );

  always #5 CLK = ~CLK;

  // Every task starts and ends at a falling edge, so inputs settle away from the sampling edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] pc);
    program_counter = pc;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RST = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    program_counter = 8'h00;
    step(2);
    checkOutput("rst_instruction", 32'(instruction), 32'h0);
    checkOutput("rst_done", 32'(load_done), 32'h0);
    checkOutput("rst_error", 32'(load_error), 32'h0);
    checkOutput("rst_count", 32'(instr_count), 32'h0);
    RST = 1'b0;

    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'hAB);
    checkOutput("basic_done_before_last", 32'(load_done), 32'h0);
    applyStimulus(8'hCD);
    checkOutput("basic_done_after_last", 32'(load_done), 32'h1);
    checkOutput("basic_count", 32'(instr_count), 32'h2);
    checkOutput("basic_error", 32'(load_error), 32'h0);
    fetch(8'd0);
    checkOutput("basic_pc0", 32'(instruction), 32'h1234);
    fetch(8'd1);
    checkOutput("basic_pc1", 32'(instruction), 32'hABCD);
    fetch(8'd2);
    checkOutput("basic_pc2_past_end", 32'(instruction), 32'h0);
    fetch(8'd255);
    checkOutput("basic_pc255", 32'(instruction), 32'h0);

    applyStimulus(8'h03);
    applyStimulus(8'h99);
    applyStimulus(8'h88);
    step(1);
    checkOutput("immune_done", 32'(load_done), 32'h1);
    checkOutput("immune_count", 32'(instr_count), 32'h2);
    fetch(8'd0);
    checkOutput("immune_pc0", 32'(instruction), 32'h1234);
    fetch(8'd1);
    checkOutput("immune_pc1", 32'(instruction), 32'hABCD);

    pulseReset();
    checkOutput("reload_rst_instruction", 32'(instruction), 32'h0);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    fetch(8'd0);
    checkOutput("early_fetch_pc0", 32'(instruction), 32'h0);
    applyStimulus(8'h34);
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    checkOutput("reload_done", 32'(load_done), 32'h1);

    pulseReset();
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    pulseReset();
    checkOutput("midrst_done", 32'(load_done), 32'h0);
    checkOutput("midrst_count", 32'(instr_count), 32'h0);
    applyStimulus(8'h01);
    applyStimulus(8'h55);
    checkOutput("midrst_done_before_last", 32'(load_done), 32'h0);
    applyStimulus(8'h66);
    checkOutput("midrst_done_after", 32'(load_done), 32'h1);
    checkOutput("midrst_count_after", 32'(instr_count), 32'h1);
    fetch(8'd0);
    checkOutput("midrst_pc0", 32'(instruction), 32'h5566);
    fetch(8'd1);
    checkOutput("midrst_pc1", 32'(instruction), 32'h0);

    // RST must win over a strobe in the same cycle
    RST = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    rx_valid = 1'b0;
    checkOutput("rst_vs_valid_error", 32'(load_error), 32'h0);

    applyStimulus(8'h00);
    checkOutput("len0_error", 32'(load_error), 32'h1);
    checkOutput("len0_done", 32'(load_done), 32'h0);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    checkOutput("len0_error_held", 32'(load_error), 32'h1);
    checkOutput("len0_done_held", 32'(load_done), 32'h0);
    checkOutput("len0_count", 32'(instr_count), 32'h0);
    fetch(8'd0);
    checkOutput("len0_pc0", 32'(instruction), 32'h0);

    pulseReset();
    applyStimulus(8'h21);
    checkOutput("len33_error", 32'(load_error), 32'h1);
    checkOutput("len33_done", 32'(load_done), 32'h0);
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    checkOutput("len33_done_held", 32'(load_done), 32'h0);
    checkOutput("len33_count", 32'(instr_count), 32'h0);

    pulseReset();
    applyStimulus(8'h20);
    checkOutput("full_error", 32'(load_error), 32'h0);
    for (int k = 0; k < 31; k++) begin
      applyStimulus(8'(k));
      applyStimulus(8'(k));
    end
    applyStimulus(8'h1F);
    checkOutput("full_done_before_last", 32'(load_done), 32'h0);
    applyStimulus(8'h1F);
    checkOutput("full_done_after_last", 32'(load_done), 32'h1);
    checkOutput("full_count", 32'(instr_count), 32'h20);
    fetch(8'd31);
    checkOutput("full_pc31", 32'(instruction), 32'h1F1F);
    fetch(8'd5);
    checkOutput("full_pc5", 32'(instruction), 32'h0505);
    fetch(8'd16);
    checkOutput("full_pc16", 32'(instruction), 32'h1010);
    fetch(8'd32);
    checkOutput("full_pc32", 32'(instruction), 32'h0);
    fetch(8'd33);
    checkOutput("full_pc33_alias", 32'(instruction), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
